csr_access_arbiter: RTL
=======================

# csr_access_arbiter

Shares the single CSR-file access port between `NUM_REQ` requesters: the core's execute stage, debug, and future agents. It arbitrates round-robin and issues each accepted access to the CSR file for exactly one cycle. It captures the pre-write read data and error flag, then returns them to the winning requester over a valid/ready response channel. It sits between the requesters and the CSR file and is the only block driving the CSR file's address, operation and write-data inputs.

## Interface
- `NUM_REQ`, 2: number of requesters (1..8).
- `DATA_WIDTH`, 64: CSR data width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit set.
- `req_addr`  in  NUM_REQ*12  packed CSR addresses; requester i at `[i*12 +: 12]`.
- `req_op`  in  NUM_REQ*2  packed ops: 00 read, 01 write, 10 set, 11 clear.
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write/mask data.
- `resp_valid`  out  NUM_REQ  one-hot response valid to the owning requester.
- `resp_ready`  in  NUM_REQ  per-requester response accept.
- `resp_rdata`  out  DATA_WIDTH  CSR value before the access.
- `resp_error`  out  1  CSR file flagged an unimplemented address.
- `csr_addr`  out  12  to CSR file.
- `csr_op`  out  2  to CSR file.
- `csr_write_data`  out  DATA_WIDTH  to CSR file.
- `csr_read_data`  in  DATA_WIDTH  combinational read data from CSR file.
- `csr_error`  in  1  combinational error from CSR file.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - If any `req_valid` is set, the round-robin winner gets `req_ready` high combinationally in the same cycle.
  - On the edge where `req_valid[w] & req_ready[w]`, latch addr/op/wdata/id from requester w and go to ISSUE.
  - `req_ready` is 0 in every state other than IDLE.
- **Round-robin**
  - Search starts at `(last_grant+1) mod NUM_REQ`.
  - `last_grant` updates only on acceptance.
  - After reset `last_grant = NUM_REQ-1`, so requester 0 has first priority.
- **ISSUE** (exactly one cycle)
  - Drive `csr_addr`, `csr_op` and `csr_write_data` from the latched request.
  - At the end of the cycle, register `csr_read_data` into `resp_rdata` and `csr_error` into `resp_error`. This is the old value, because the CSR file commits the write on the same edge.
  - Go to RESP.
- **RESP**
  - `resp_valid[id]=1` until `resp_ready[id]` is sampled high, then go to IDLE.
  - `resp_ready` bits of other requesters are ignored.
  - `resp_rdata` and `resp_error` are stable while `resp_valid` is high.
- **CSR port outside ISSUE:** `csr_op = 00`, so the CSR file never sees a spurious write. `csr_addr` and `csr_write_data` hold the last issued values; `csr_addr` is 0 after reset.
- **Errors:** an error response is a normal response. The arbiter does not suppress or retry the access.
- **Reset:** `rst` high in any state, including ISSUE, forces:
  - `csr_op = 00` combinationally in that cycle, so no CSR write happens.
  - State to IDLE, with any in-flight response dropped.
  - Outputs: `req_ready=0`, `resp_valid=0`, `resp_rdata=0`, `resp_error=0`, `csr_addr=0`, `csr_write_data=0`.

## Timing
- Request accepted at edge N.
- ISSUE in cycle N..N+1; the CSR write commits at edge N+1.
- `resp_valid` is high from cycle N+1 onward.
- Minimum occupancy is 3 cycles per access (IDLE, ISSUE, RESP) when `resp_ready` is held high.
- Back-to-back: a new acceptance can happen in the IDLE cycle after the RESP handshake, giving 1 access per 3 cycles.
- A requester holding `req_valid` through a busy period waits. It gets served within NUM_REQ accesses, with no starvation.
- Requesters must keep addr/op/wdata stable while `req_valid` is high and `req_ready` is low.

## Test plan
- **Single read:** after reset, req0 reads 0xC00 while the CSR file returns 0x1234.
  - `req_ready[0]` is high in the same cycle.
  - `csr_op=00` and `csr_addr=0xC00` in ISSUE.
  - `resp_valid[0]` is high with `resp_rdata=0x1234` and `resp_error=0`, one cycle after acceptance.
- **Write returns old value:** req1 writes 0xB03 with 0xFF while the register holds 0x10.
  - `csr_op=01` for exactly one cycle.
  - `resp_rdata=0x10`.
  - A subsequent read returns 0xFF.
- **Contention:** req0 and req1 are both valid continuously, with `resp_ready` tied high.
  - Grant order is 0,1,0,1.
  - There are 3 cycles between acceptances.
  - `req_ready` is never set for both requesters at once.
- **Response backpressure:** `resp_ready[0]` is held low for 5 cycles.
  - `resp_valid[0]` and `resp_rdata` stay stable.
  - `req_ready` stays 0 throughout.
  - The next grant comes only after the handshake.
- **Unimplemented address:** req0 sets bits at 0x7FF.
  - `resp_error=1` and `resp_rdata=0`.
  - The FSM returns to IDLE normally.
- **Reset in ISSUE:** assert `rst` during the ISSUE cycle of a write to 0xC02.
  - `csr_op=00` in that cycle.
  - The 0xC02 value is unchanged.
  - `resp_valid=0`.
  - Requester 0 has priority on the next request.

Source files
------------

// File: rtl/csr_access_arbiter_if.sv
// Bundle of requester-side and CSR-file-side signals around csr_access_arbiter.
// Handshake rule for both req_* and resp_*: a transfer happens on the rising edge where valid & ready are both high.
interface csr_access_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*12-1:0]         req_addr;
  logic [NUM_REQ*2-1:0]          req_op;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [NUM_REQ-1:0]            resp_ready;
  logic [DATA_WIDTH-1:0]         resp_rdata;
  logic                          resp_error;
  logic [11:0]                   csr_addr;
  logic [1:0]                    csr_op;
  logic [DATA_WIDTH-1:0]         csr_write_data;
  logic [DATA_WIDTH-1:0]         csr_read_data;
  logic                          csr_error;

  modport master (
    output req_valid, req_addr, req_op, req_wdata, resp_ready, csr_read_data, csr_error,
    input  req_ready, resp_valid, resp_rdata, resp_error, csr_addr, csr_op, csr_write_data
  );

  modport slave (
    input  req_valid, req_addr, req_op, req_wdata, resp_ready, csr_read_data, csr_error,
    output req_ready, resp_valid, resp_rdata, resp_error, csr_addr, csr_op, csr_write_data
  );
endinterface

// File: rtl/csr_access_arbiter.sv
// Round-robin arbiter sharing one CSR-file port among NUM_REQ requesters.
// Each access is IDLE (grant) -> ISSUE (one CSR cycle) -> RESP (hold until resp handshake).
module csr_access_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  csr_access_arbiter_if.slave  bus,
  output logic [1:0]           dbg_state
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [IDX_W-1:0]       id_q, id_d;
  logic [11:0]            addr_q, addr_d;
  logic [1:0]             op_q, op_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   error_q, error_d;
  logic [IDX_W-1:0]       win;
  logic [IDX_W-1:0]       cand;
  logic                   found;

  // First valid requester at or after last_q+1, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    id_d           = id_q;
    addr_d         = addr_q;
    op_d           = op_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    error_d        = error_q;
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.csr_op     = 2'b00;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            bus.req_ready = NUM_REQ'(1) << win;
            state_d       = ISSUE;
            last_d        = win;
            id_d          = win;
            addr_d        = bus.req_addr[win*12 +: 12];
            op_d          = bus.req_op[win*2 +: 2];
            wdata_d       = bus.req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        ISSUE: begin
          // The CSR file commits on this same edge, so the captured value is the pre-access one.
          bus.csr_op = op_q;
          rdata_d    = bus.csr_read_data;
          error_d    = bus.csr_error;
          state_d    = RESP;
        end
        RESP: begin
          bus.resp_valid = NUM_REQ'(1) << id_q;
          if (bus.resp_ready[id_q]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      id_q    <= '0;
      addr_q  <= '0;
      op_q    <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign bus.csr_addr       = addr_q;
  assign bus.csr_write_data = wdata_q;
  assign bus.resp_rdata     = rdata_q;
  assign bus.resp_error     = error_q;
  assign dbg_state          = state_q;
endmodule
